// File: rtl/bcd_cascade_pkg.sv
// Shared BCD types and helpers for the cascadable BCD counter.
// Vectors are handled at the maximum width of 8 digits and zero-extended by callers.
package bcd_cascade_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // True when each of the lowest n nibbles of v is a decimal digit (0..9).
    function automatic logic bcd_valid(input logic [BCD_W*MAX_DIGITS-1:0] v, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && v[i*BCD_W +: BCD_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // True when a <= b, comparing digit by digit from the most significant end.
    function automatic logic bcd_le(input logic [BCD_W*MAX_DIGITS-1:0] a,
                                    input logic [BCD_W*MAX_DIGITS-1:0] b);
        logic decided;
        logic le;
        decided = 1'b0;
        le      = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided) begin
                if (a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W]) begin
                    le      = 1'b1;
                    decided = 1'b1;
                end else if (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]) begin
                    le      = 1'b0;
                    decided = 1'b1;
                end
            end
        end
        return le;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register that wraps 9<->0 when stepped.
// Priority: clr > ld > inc > dec.
module bcd_digit
    import bcd_cascade_pkg::*;
(
    input  logic       clk,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (inc) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_cascade_counter.sv
// N-digit synchronous BCD counter with programmable terminal value and cascade carry.
// Define BCD_CASCADE_COUNTER_DOWN_EN to enable down counting through up_dn.
module bcd_cascade_counter
    import bcd_cascade_pkg::*;
#(
    parameter int                      NUM_DIGITS = 2,
    parameter logic [4*NUM_DIGITS-1:0] TOP        = 8'h59
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] d,
    output logic [4*NUM_DIGITS-1:0] q,
    output logic                    tc,
    output logic                    co,
    output logic                    load_err
);

    localparam int W = BCD_W * NUM_DIGITS;

    logic                  count_down;
    logic                  at_top;
    logic                  load_legal;
    logic                  wrap;
    logic                  clr_all;
    logic [W-1:0]          wrap_val;
    logic                  low_nine;
    logic [NUM_DIGITS-1:0] digit_inc;
    logic [NUM_DIGITS-1:0] digit_dec;

    assign at_top = (q == TOP);

`ifdef BCD_CASCADE_COUNTER_DOWN_EN
    logic at_zero;
    logic low_zero;

    assign count_down = ~up_dn;
    assign at_zero    = (q == '0);
    assign tc         = count_down ? at_zero : at_top;
    assign wrap_val   = count_down ? TOP : '0;
`else
    logic unused_up_dn;

    assign unused_up_dn = up_dn;
    assign count_down   = 1'b0;
    assign tc           = at_top;
    assign wrap_val     = '0;
`endif

    assign co         = en & tc;
    assign load_legal = bcd_valid(32'(d), NUM_DIGITS) && bcd_le(32'(d), 32'(TOP));
    // The terminal-value wrap overrides per-digit carries, so TOP need not end in 9s.
    assign wrap       = co & ~load;
    assign clr_all    = rst | (load & ~load_legal);

    // A digit steps only when every lower digit is about to roll over.
    always_comb begin
        digit_inc = '0;
        digit_dec = '0;
        low_nine  = 1'b1;
`ifdef BCD_CASCADE_COUNTER_DOWN_EN
        low_zero  = 1'b1;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_inc[i] = en & ~count_down & low_nine;
            low_nine     = low_nine & (q[i*BCD_W +: BCD_W] == 4'd9);
`ifdef BCD_CASCADE_COUNTER_DOWN_EN
            digit_dec[i] = en & count_down & low_zero;
            low_zero     = low_zero & (q[i*BCD_W +: BCD_W] == 4'd0);
`endif
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .inc    (digit_inc[g]),
            .dec    (digit_dec[g]),
            .clr    (clr_all),
            .ld     (load | wrap),
            .ld_val (load ? d[g*BCD_W +: BCD_W] : wrap_val[g*BCD_W +: BCD_W]),
            .q      (q[g*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~load_legal;
        end
    end

endmodule
